// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: signed binary to packed BCD via iterative shift-add-3,
// saturating to all nines with an overflow flag when |value| exceeds the digit range.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [WIDTH-1:0]    bin_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [4*DIGITS-1:0] bcd_o,
    output logic                neg_o,
    output logic                ovf_o
);
    localparam int LIMIT = 10**DIGITS - 1;
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] IDLE = 2'd0, CONV = 2'd1, DONE = 2'd2;

    logic [1:0]          r_state;
    logic [CW-1:0]       r_cnt;
    logic [WIDTH-1:0]    r_mag;
    logic [4*DIGITS-1:0] r_scr;
    logic                r_sign;
    logic                r_ovf_q;
    logic                r_done;
    logic [4*DIGITS-1:0] r_bcd;
    logic                r_neg;
    logic                r_ovf;
    logic [WIDTH-1:0]    w_mag;
    logic                w_ovf;
    logic [4*DIGITS-1:0] w_adj;
    logic [4*DIGITS-1:0] w_scr_nx;

    // The most negative input negates to itself, which is the correct unsigned magnitude.
    assign w_mag = bin_i[WIDTH-1] ? -bin_i : bin_i;
    assign w_ovf = 64'(w_mag) > 64'(LIMIT);

    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        assign w_adj[4*d +: 4] = (r_scr[4*d +: 4] >= 4'd5) ? r_scr[4*d +: 4] + 4'd3 : r_scr[4*d +: 4];
    end

    // Carry out of the top nibble is dropped; overflowed results are replaced by nines anyway.
    assign w_scr_nx = {w_adj[4*DIGITS-2:0], r_mag[WIDTH-1]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_mag   <= '0;
            r_scr   <= '0;
            r_sign  <= 1'b0;
            r_ovf_q <= 1'b0;
            r_done  <= 1'b0;
            r_bcd   <= '0;
            r_neg   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (start_i) begin
                    r_state <= CONV;
                    r_sign  <= bin_i[WIDTH-1];
                    r_mag   <= w_mag;
                    r_ovf_q <= w_ovf;
                    r_scr   <= '0;
                    r_cnt   <= CW'(WIDTH - 1);
                end
            end else if (r_state == CONV) begin
                r_scr <= w_scr_nx;
                r_mag <= {r_mag[WIDTH-2:0], 1'b0};
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == '0) begin
                    r_state <= DONE;
                    r_bcd   <= r_ovf_q ? {DIGITS{4'h9}} : w_scr_nx;
                    r_neg   <= r_sign;
                    r_ovf   <= r_ovf_q;
                    r_done  <= 1'b1;
                end
            end else begin
                r_state <= IDLE;
            end
        end
    end

    assign busy_o = (r_state == CONV);
    assign done_o = r_done;
    assign bcd_o  = r_bcd;
    assign neg_o  = r_neg;
    assign ovf_o  = r_ovf;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: table vectors, hand-written corner sequences and random values
// against an arithmetic reference model.
module tb_bin_to_bcd_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic [15:0] bin_i = '0;
    logic        busy_o;
    logic        done_o;
    logic [15:0] bcd_o;
    logic        neg_o;
    logic        ovf_o;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(4)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .bin_i(bin_i),
        .busy_o(busy_o), .done_o(done_o), .bcd_o(bcd_o), .neg_o(neg_o), .ovf_o(ovf_o)
    );

    typedef struct {
        logic [15:0] bin;
        logic [15:0] bcd;
        logic        neg;
        logic        ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: decimal digits by division, saturation and sign straight from the value.
    function automatic logic [17:0] ref_model(input logic [15:0] b);
        int v;
        int m;
        int r;
        logic [15:0] d;
        v = int'($signed(b));
        m = (v < 0) ? -v : v;
        r = m;
        d = '0;
        if (m > 9999) d = 16'h9999;
        else for (int i = 0; i < 4; i++) begin
            d[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return {v < 0, m > 9999, d};
    endfunction

    task automatic wait_done(output int n);
        n = 0;
        while (!done_o && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    // One conversion with latency, busy and single-cycle done checks; bin_i is scrambled mid-flight.
    task automatic run(input string name, input logic [15:0] b, input logic [15:0] eb, input logic en, input logic eo);
        int lat;
        int bz;
        @(negedge clk);
        start_i = 1'b1;
        bin_i = b;
        @(negedge clk);
        start_i = 1'b0;
        bin_i = 16'($urandom);
        lat = 1;
        bz = 0;
        while (!done_o && lat < 40) begin
            if (busy_o) bz++;
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, lat, 17);
        chk({name, "_busy_cycles"}, bz, 16);
        chk({name, "_bcd"}, bcd_o, eb);
        chk({name, "_neg"}, neg_o, en);
        chk({name, "_ovf"}, ovf_o, eo);
        @(negedge clk);
        chk({name, "_done_pulse"}, done_o, 0);
        chk({name, "_bcd_hold"}, bcd_o, eb);
    endtask

    initial begin
        logic [17:0] r;
        logic [15:0] b;
        int n;
        int seen;
        vecs[0] = '{16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[1] = '{16'h04D2, 16'h1234, 1'b0, 1'b0};
        vecs[2] = '{16'hD9B7, 16'h9801, 1'b1, 1'b0};
        vecs[3] = '{16'd10000, 16'h9999, 1'b0, 1'b1};
        vecs[4] = '{16'h8000, 16'h9999, 1'b1, 1'b1};
        vecs[5] = '{16'd9999, 16'h9999, 1'b0, 1'b0};
        vecs[6] = '{16'hD8F1, 16'h9999, 1'b1, 1'b0};
        vecs[7] = '{16'hD8F0, 16'h9999, 1'b1, 1'b1};
        vecs[8] = '{16'h7FFF, 16'h9999, 1'b0, 1'b1};
        vecs[9] = '{16'hFFFF, 16'h0001, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_bcd", bcd_o, 0);
        chk("reset_flags", {busy_o, done_o, neg_o, ovf_o}, 0);
        rst = 1'b1;

        for (int i = 0; i < 10; i++)
            run($sformatf("vec%0d", i), vecs[i].bin, vecs[i].bcd, vecs[i].neg, vecs[i].ovf);

        // start held high through CONV and DONE with bin_i changed: no queued or restarted request
        @(negedge clk);
        start_i = 1'b1;
        bin_i = 16'h04D2;
        @(negedge clk);
        bin_i = 16'hFFFF;
        wait_done(n);
        chk("hold_first_bcd", bcd_o, 16'h1234);
        chk("hold_first_neg", neg_o, 0);
        @(negedge clk);
        chk("hold_idle_gap_busy", busy_o, 0);
        @(negedge clk);
        start_i = 1'b0;
        chk("hold_second_busy", busy_o, 1);
        wait_done(n);
        chk("hold_second_bcd", bcd_o, 16'h0001);
        chk("hold_second_neg", neg_o, 1);
        chk("hold_second_ovf", ovf_o, 0);

        // reset on the 8th CONV cycle aborts the conversion
        @(negedge clk);
        start_i = 1'b1;
        bin_i = 16'h04D2;
        @(negedge clk);
        start_i = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort_busy_before", busy_o, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_bcd", bcd_o, 0);
        chk("abort_flags", {busy_o, done_o, neg_o, ovf_o}, 0);
        rst = 1'b1;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (done_o || busy_o) seen++;
        end
        chk("abort_no_done", seen, 0);
        run("after_abort", 16'd42, 16'h0042, 1'b0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            b = (i % 2 == 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 19998)) - 9999);
            r = ref_model(b);
            run($sformatf("rand_%04h", b), b, r[15:0], r[17], r[16]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
